// File: rtl/key_code_shifter.sv
// key_code_shifter
//   Serial code entry front end for the switch-code checker. The user sets
//   the data switch, presses the shift button to clock that bit in, repeats
//   until WIDTH bits are held, then presses submit. A complete entry is
//   presented on code_out with a one-cycle code_valid strobe. A short entry
//   produces a one-cycle err strobe instead. check_mode tells the checker
//   whether the code belongs to the normal set (0) or is the final code (1).
//
//   Optional build macro: KEY_SHIFTER_LSB_FIRST_EN selects LSB-first entry
//   (first entered bit lands in bit 0). Default is MSB-first.
//
//   Ports:
//     clk         system clock (only clock)
//     rst_n       synchronous active-low reset
//     key_bit     raw data switch, the bit to shift in (synchronised only)
//     key_shift   raw shift button, active-high (synchronised + debounced)
//     key_submit  raw submit button, active-high (synchronised + debounced)
//     code_out    last submitted code, held until the next valid submit
//     code_valid  one-cycle pulse when code_out updates
//     check_mode  0 = normal code set, 1 = final-code entry
//     bit_count   bits entered so far, 0..WIDTH (WIDTH = full state)
//     err         one-cycle pulse on submit with bit_count != WIDTH
//
//   Handshake: code_valid is a single-cycle strobe with no back-pressure;
//   code_out and check_mode are stable from the strobe cycle onward until
//   the next strobe, so a consumer may sample them on or after the strobe.
module key_code_shifter #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int FINAL_AFTER     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_bit,
  input  logic             key_shift,
  input  logic             key_submit,
  output logic [WIDTH-1:0] code_out,
  output logic             code_valid,
  output logic             check_mode,
  output logic [3:0]       bit_count,
  output logic             err
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SC_W = $clog2(FINAL_AFTER + 1);
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SC_W-1:0] SC_FINAL  = SC_W'(FINAL_AFTER);
  localparam logic [3:0]      FULL      = 4'(WIDTH);

  // 2-FF synchronisers
  logic bit_s1_q, bit_s1_d, bit_s2_q, bit_s2_d;
  logic shift_s1_q, shift_s1_d, shift_s2_q, shift_s2_d;
  logic submit_s1_q, submit_s1_d, submit_s2_q, submit_s2_d;

  // debounce state
  logic [DB_W-1:0] shift_cnt_q, shift_cnt_d;
  logic [DB_W-1:0] submit_cnt_q, submit_cnt_d;
  logic shift_db_q, shift_db_d, shift_prev_q, shift_prev_d;
  logic submit_db_q, submit_db_d, submit_prev_q, submit_prev_d;

  // entry / output state
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [3:0]       bit_count_q, bit_count_d;
  logic [WIDTH-1:0] code_out_q, code_out_d;
  logic             code_valid_q, code_valid_d;
  logic             err_q, err_d;
  logic             check_mode_q, check_mode_d;
  logic [SC_W-1:0]  sub_cnt_q, sub_cnt_d;

  logic            shift_rise, submit_rise;
  logic [SC_W-1:0] sub_cnt_next;

  always_comb begin
    bit_s1_d      = key_bit;
    bit_s2_d      = bit_s1_q;
    shift_s1_d    = key_shift;
    shift_s2_d    = shift_s1_q;
    submit_s1_d   = key_submit;
    submit_s2_d   = submit_s1_q;

    shift_cnt_d   = '0;
    shift_db_d    = shift_db_q;
    submit_cnt_d  = '0;
    submit_db_d   = submit_db_q;
    shift_prev_d  = shift_db_q;
    submit_prev_d = submit_db_q;

    sreg_d        = sreg_q;
    bit_count_d   = bit_count_q;
    code_out_d    = code_out_q;
    code_valid_d  = 1'b0;
    err_d         = 1'b0;
    check_mode_d  = check_mode_q;
    sub_cnt_d     = sub_cnt_q;
    sub_cnt_next  = sub_cnt_q + 1'b1;

    // Debounce: the counter runs only while synced and debounced levels
    // disagree; the cycle it would reach DEBOUNCE_CYCLES the level flips.
    if (shift_s2_q != shift_db_q) begin
      if (shift_cnt_q == DB_LAST) shift_db_d = shift_s2_q;
      else                        shift_cnt_d = shift_cnt_q + 1'b1;
    end
    if (submit_s2_q != submit_db_q) begin
      if (submit_cnt_q == DB_LAST) submit_db_d = submit_s2_q;
      else                         submit_cnt_d = submit_cnt_q + 1'b1;
    end

    // Edges come from the debounced level and its one-cycle-old copy, so
    // the action lands one cycle after the debounced level rises.
    shift_rise  = shift_db_q & ~shift_prev_q;
    submit_rise = submit_db_q & ~submit_prev_q;

    // Submit has priority; a coincident shift edge is dropped.
    if (submit_rise) begin
      if (bit_count_q == FULL) begin
        code_out_d   = sreg_q;
        code_valid_d = 1'b1;
        sreg_d       = '0;
        bit_count_d  = '0;
        if (check_mode_q) begin
          check_mode_d = 1'b0;
          sub_cnt_d    = '0;
        end else begin
          sub_cnt_d = sub_cnt_next;
          if (sub_cnt_next == SC_FINAL) check_mode_d = 1'b1;
        end
      end else begin
        err_d = 1'b1;
      end
    end else if (shift_rise && (bit_count_q != FULL)) begin
`ifdef KEY_SHIFTER_LSB_FIRST_EN
      sreg_d = {bit_s2_q, sreg_q[WIDTH-1:1]};
`else
      sreg_d = {sreg_q[WIDTH-2:0], bit_s2_q};
`endif
      bit_count_d = bit_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_s1_q      <= 1'b0;
      bit_s2_q      <= 1'b0;
      shift_s1_q    <= 1'b0;
      shift_s2_q    <= 1'b0;
      submit_s1_q   <= 1'b0;
      submit_s2_q   <= 1'b0;
      shift_cnt_q   <= '0;
      submit_cnt_q  <= '0;
      shift_db_q    <= 1'b0;
      submit_db_q   <= 1'b0;
      shift_prev_q  <= 1'b0;
      submit_prev_q <= 1'b0;
      sreg_q        <= '0;
      bit_count_q   <= '0;
      code_out_q    <= '0;
      code_valid_q  <= 1'b0;
      err_q         <= 1'b0;
      check_mode_q  <= 1'b0;
      sub_cnt_q     <= '0;
    end else begin
      bit_s1_q      <= bit_s1_d;
      bit_s2_q      <= bit_s2_d;
      shift_s1_q    <= shift_s1_d;
      shift_s2_q    <= shift_s2_d;
      submit_s1_q   <= submit_s1_d;
      submit_s2_q   <= submit_s2_d;
      shift_cnt_q   <= shift_cnt_d;
      submit_cnt_q  <= submit_cnt_d;
      shift_db_q    <= shift_db_d;
      submit_db_q   <= submit_db_d;
      shift_prev_q  <= shift_prev_d;
      submit_prev_q <= submit_prev_d;
      sreg_q        <= sreg_d;
      bit_count_q   <= bit_count_d;
      code_out_q    <= code_out_d;
      code_valid_q  <= code_valid_d;
      err_q         <= err_d;
      check_mode_q  <= check_mode_d;
      sub_cnt_q     <= sub_cnt_d;
    end
  end

  assign code_out   = code_out_q;
  assign code_valid = code_valid_q;
  assign check_mode = check_mode_q;
  assign bit_count  = bit_count_q;
  assign err        = err_q;

endmodule

// File: doc/key_code_shifter.md
Name: key_code_shifter

Overview:
- Writer side of the switch-code checking path: the user enters a 10-bit code serially with one data switch and one shift button, then presses a submit button.
- The block presents the assembled parallel word and a one-cycle valid strobe to the code checker.
- It also drives the checker's mode input: normal code set, or final code.
- It sits between the raw Marsohod GPIO buttons/switches and the checker.

Parameters:
- WIDTH, 10, code length in bits; the checker consumes 10.
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles needed before a debounced level changes; minimum 1.
- FINAL_AFTER, 3, number of valid submits in normal mode before check_mode asserts.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- key_bit  input  1  raw data switch; level is the bit to shift in
- key_shift  input  1  raw shift button, active-high
- key_submit  input  1  raw submit button, active-high
- code_out  output  WIDTH  last submitted code; held until next valid submit
- code_valid  output  1  one-cycle pulse when code_out updates
- check_mode  output  1  0 = normal code set, 1 = final-code entry; drives the checker mode input
- bit_count  output  4  bits entered so far, range 0..WIDTH
- err  output  1  one-cycle pulse on submit with bit_count != WIDTH

Behaviour:
- Reset: clk is the only clock. Reset is synchronous, active-low, sampled on the clk rising edge (rst_n = 0 at a rising clk edge resets). It overrides everything.
- Reset values: code_out = 0, code_valid = 0, check_mode = 0, bit_count = 0, err = 0. The internal shift register, submit counter, synchronisers, debounce counters and debounced levels are all 0.
- Synchronisation: all three raw inputs pass through a 2-FF synchroniser.
- Debounce: key_shift and key_submit each have a counter. While the synced value differs from the debounced level, the counter increments. When it reaches DEBOUNCE_CYCLES, the debounced level takes the synced value and the counter clears. Any cycle where they agree clears the counter. key_bit is synchronised only, not debounced.
- Edge detection: an action fires on a 0->1 change of a debounced level; it is registered one cycle after that change.
- Total latency from a raw button rising (held stable) to the output effect is 3 + DEBOUNCE_CYCLES cycles.
- Collect state (bit_count < WIDTH), shift edge:
  - MSB-first: sreg <= {sreg[WIDTH-2:0], synced key_bit}.
  - bit_count increments.
  - Moves to the full state when bit_count reaches WIDTH.
- Full state (bit_count == WIDTH): shift edges are ignored; sreg and bit_count are unchanged.
- Submit edge with bit_count == WIDTH:
  - code_out <= sreg; code_valid pulses for 1 cycle.
  - sreg and bit_count clear to 0; returns to the collect state.
- Submit edge with bit_count < WIDTH:
  - err pulses for 1 cycle.
  - code_out, sreg, bit_count and the submit counter are unchanged.
- Mode sequencing:
  - In normal mode (check_mode = 0), each valid submit increments the submit counter.
  - When the counter reaches FINAL_AFTER, check_mode <= 1 in the same cycle as that code_valid pulse.
  - The next valid submit while check_mode = 1 pulses code_valid, then check_mode <= 0 and the counter clears.
  - An err submit never changes the mode.
- Simultaneous shift and submit edges in the same cycle: submit is processed and the shift is dropped.
- code_valid and err are never high together.
- bit_count never exceeds WIDTH.
- Reset mid-entry discards any partial code. Reset mid-debounce discards pending edges.

Optional Feature:
- Macro: KEY_SHIFTER_LSB_FIRST_EN.
- Defined: LSB-first entry, sreg <= {synced key_bit, sreg[WIDTH-1:1]}; the first entered bit ends in bit 0.
- Undefined (default): MSB-first as above; the first entered bit ends in bit WIDTH-1.
- No other behaviour differs.

Test Plan (benches use DEBOUNCE_CYCLES = 4 and default WIDTH / FINAL_AFTER unless stated):
- Reset: hold rst_n = 0 for 3 cycles with all keys toggling -> all outputs 0 and bit_count = 0. Release with keys at 0 -> no pulses.
- Enter bits 1,1,0,1,0,0,1,1,0,0 (MSB-first), each shift press held 10 cycles, then submit:
  - code_out = 10'b1101001100.
  - code_valid high exactly 1 cycle, 7 cycles after the raw submit rises.
  - bit_count returns to 0.
- Submit after only 6 shifts -> err pulses 1 cycle; code_out unchanged; bit_count stays 6. An 11th shift after 10 bits -> bit_count stays 10.
- Bounce: key_shift toggling every 2 cycles for 20 cycles, then held 1 -> exactly one shift, bit_count +1.
- Three valid submits -> check_mode rises with the 3rd code_valid. The 4th valid submit -> code_valid pulses, then check_mode = 0.
- Same debounced-cycle shift and submit edges with bit_count = 10 -> code_valid pulses, bit_count = 0, no shifted bit retained. With KEY_SHIFTER_LSB_FIRST_EN defined, the same 10-bit entry -> code_out = 10'b0011001011.
